// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with valid/ready handshakes, zero/parity flags and a tag
// that travels with each operation. Outputs are driven straight from stage-2 registers.
module logic_unit_pipe #(
  parameter int unsigned OPERANDSIZE = 64,
  parameter int unsigned TAGWIDTH    = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [OPERANDSIZE-1:0] in_a,
  input  logic [OPERANDSIZE-1:0] in_b,
  input  logic [TAGWIDTH-1:0]    in_tag,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OPERANDSIZE-1:0] out_q,
  output logic                   out_zero,
  output logic                   out_parity,
  output logic [TAGWIDTH-1:0]    out_tag
);

  logic                   s1_valid;
  logic [2:0]             s1_op;
  logic [OPERANDSIZE-1:0] s1_a;
  logic [OPERANDSIZE-1:0] s1_b;
  logic [TAGWIDTH-1:0]    s1_tag;

  logic                   s2_valid;
  logic [OPERANDSIZE-1:0] s2_q;
  logic                   s2_zero;
  logic                   s2_parity;
  logic [TAGWIDTH-1:0]    s2_tag;

  logic                   s1_adv;
  logic                   s2_adv;
  logic [OPERANDSIZE-1:0] res;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !flush;

  always_comb begin
    res = '0;
    case (s1_op)
      3'b000:  res = s1_a & s1_b;
      3'b001:  res = s1_a | s1_b;
      3'b010:  res = s1_a ^ s1_b;
      3'b011:  res = s1_a & ~s1_b;
      3'b100:  res = s1_a | ~s1_b;
      3'b101:  res = ~(s1_a ^ s1_b);
      3'b110:  res = s1_a;
      default: res = ~s1_a;
    endcase
  end

  // Data registers only capture on advance; a flush just kills the valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (s1_adv) begin
        s1_valid <= in_valid;
      end
      if (s1_adv) begin
        s1_op  <= in_op;
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_tag <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_q      <= '0;
      s2_zero   <= 1'b1;
      s2_parity <= 1'b0;
      s2_tag    <= '0;
    end else begin
      if (flush) begin
        s2_valid <= 1'b0;
      end else if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s2_adv) begin
        s2_q      <= res;
        s2_zero   <= ~|res;
        s2_parity <= ^res;
        s2_tag    <= s1_tag;
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_q      = s2_q;
  assign out_zero   = s2_zero;
  assign out_parity = s2_parity;
  assign out_tag    = s2_tag;

endmodule
